// File: rtl/register_file.sv
// 32x32 integer register file: two combinational read ports, one synchronous write port, x0 hardwired to zero.
// Define REGFILE_BYPASS_EN to forward same-cycle write data onto matching read ports.
module register_file #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] addr_rs1,
  input  logic [ADDR_WIDTH-1:0] addr_rs2,
  input  logic [ADDR_WIDTH-1:0] addr_rd,
  input  logic [DATA_WIDTH-1:0] data_rd,
  input  logic                  we,
  output logic [DATA_WIDTH-1:0] data_rs1,
  output logic [DATA_WIDTH-1:0] data_rs2
);

  localparam int unsigned NUM_REGS = 2 ** ADDR_WIDTH;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS_EN = 1'b1;
`else
  localparam bit BYPASS_EN = 1'b0;
`endif

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  wr_en;

  // x0 is never a write target, so its reset value persists
  assign wr_en = we && (addr_rd != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[addr_rd] <= data_rd;
    end
  end

  // Read port 1; gated by rst so the bypass cannot leak data during reset
  always_comb begin
    data_rs1 = '0;
    if (rst && (addr_rs1 != '0)) begin
      if (BYPASS_EN && wr_en && (addr_rs1 == addr_rd)) begin
        data_rs1 = data_rd;
      end else begin
        data_rs1 = regs[addr_rs1];
      end
    end
  end

  // Read port 2, independent of port 1
  always_comb begin
    data_rs2 = '0;
    if (rst && (addr_rs2 != '0)) begin
      if (BYPASS_EN && wr_en && (addr_rs2 == addr_rd)) begin
        data_rs2 = data_rd;
      end else begin
        data_rs2 = regs[addr_rs2];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file: expectations queued at drive time, popped and asserted at sample time.
module tb_register_file;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 5;

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] addr_rs1, addr_rs2, addr_rd;
  logic [DW-1:0] data_rd;
  logic          we;
  logic [DW-1:0] data_rs1, data_rs2;

  typedef struct {
    int          port;
    logic [31:0] val;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          passed = 0;
  logic [31:0] model [32];

  register_file #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .addr_rs1(addr_rs1), .addr_rs2(addr_rs2),
    .addr_rd(addr_rd), .data_rd(data_rd), .we(we),
    .data_rs1(data_rs1), .data_rs2(data_rs2)
  );

  always #5 clk = ~clk;

  task automatic expect_port(input int port, input logic [31:0] val, input string tag);
    exp_t e;
    e.port = port;
    e.val  = val;
    e.tag  = tag;
    sb.push_back(e);
  endtask

  task automatic check_all();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = (e.port == 1) ? data_rs1 : data_rs2;
      total++;
      assert (obs === e.val) passed++;
      else $error("FAIL %s: rs%0d observed=%h expected=%h", e.tag, e.port, obs, e.val);
    end
  endtask

  // Write presented at a negedge, committed by the following posedge
  task automatic write_reg(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    @(negedge clk);
    we = 1'b1; addr_rd = rd; data_rd = d;
    @(negedge clk);
    we = 1'b0;
    if (rd != '0) model[rd] = d;
  endtask

  task automatic read_pair(input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                           input logic [31:0] e1, input logic [31:0] e2, input string tag);
    addr_rs1 = a1; addr_rs2 = a2;
    expect_port(1, e1, tag);
    expect_port(2, e2, tag);
    #1;
    check_all();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = '0;
    rst = 1'b0; we = 1'b0; addr_rs1 = '0; addr_rs2 = '0; addr_rd = '0; data_rd = '0;
    #12;
    @(negedge clk);
    rst = 1'b1;
    read_pair(5'd7, 5'd31, 32'h0, 32'h0, "reset_state");

    // Asynchronous reset clears x7 before any clock edge
    write_reg(5'd7, 32'h1111_1111);
    read_pair(5'd7, 5'd7, 32'h1111_1111, 32'h1111_1111, "x7_written");
    #1;
    rst = 1'b0;
    read_pair(5'd7, 5'd0, 32'h0, 32'h0, "async_reset");
    we = 1'b1; addr_rd = 5'd7; data_rd = 32'hAAAA_AAAA;
    read_pair(5'd7, 5'd7, 32'h0, 32'h0, "reset_no_bypass");
    @(posedge clk);
    read_pair(5'd7, 5'd7, 32'h0, 32'h0, "reset_write_ignored");
    @(negedge clk);
    we = 1'b0;
    rst = 1'b1;
    model[7] = '0;
    read_pair(5'd7, 5'd1, 32'h0, 32'h0, "after_reset");

    write_reg(5'd5, 32'hABCD_1234);
    read_pair(5'd5, 5'd0, 32'hABCD_1234, 32'h0, "basic_write");

    write_reg(5'd0, 32'hFFFF_FFFF);
    read_pair(5'd0, 5'd0, 32'h0, 32'h0, "x0_protect");

    write_reg(5'd3, 32'h0000_0033);
    write_reg(5'd4, 32'h0000_0044);
    read_pair(5'd3, 5'd4, 32'h33, 32'h44, "dual_read");
    read_pair(5'd4, 5'd4, 32'h44, 32'h44, "same_addr");

    // Read during write; port 2 reads a non-matching address
    write_reg(5'd9, 32'hDEAD_BEEF);
    @(negedge clk);
    we = 1'b1; addr_rd = 5'd9; data_rd = 32'h0000_0009;
    read_pair(5'd9, 5'd3, BYP ? 32'h9 : 32'hDEAD_BEEF, 32'h33, "rdw_before_edge");
    @(posedge clk);
    read_pair(5'd9, 5'd9, 32'h9, 32'h9, "rdw_after_edge");
    model[9] = 32'h9;
    @(negedge clk);
    addr_rd = 5'd0; data_rd = 32'hFFFF_FFFF;
    read_pair(5'd0, 5'd9, 32'h0, 32'h9, "x0_bypass");
    @(negedge clk);
    we = 1'b0;

    // we=0 with live address/data must not disturb x5
    addr_rd = 5'd5; data_rd = 32'h5555_5555;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      read_pair(5'd5, 5'd5, 32'hABCD_1234, 32'hABCD_1234, "we0_hold");
    end

    for (int i = 1; i < 32; i++) write_reg(AW'(i), $urandom);
    for (int i = 0; i < 32; i++) read_pair(AW'(i), AW'(31 - i), model[i], model[31 - i], "sweep");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
